// File: rtl/exc_pkg.sv
// exc_pkg: exception flag layout, cp0 ExcCodes, default vectors and FSM states
package exc_pkg;
    // mem_exc[6:0] are one-hot fetch/decode/execute flags; mem_exc[9:7] encodes
    // the single data-side fault together with its load/store qualifier.
    localparam int EXC_W       = 10;
    localparam int B_IF_ADEL   = 0;
    localparam int B_IF_REFILL = 1;
    localparam int B_IF_INV    = 2;
    localparam int B_RI        = 3;
    localparam int B_OV        = 4;
    localparam int B_SYS       = 5;
    localparam int B_BP        = 6;
    localparam int B_DATA      = 7;

    localparam logic [2:0] D_NONE     = 3'd0;
    localparam logic [2:0] D_ADEL     = 3'd1;
    localparam logic [2:0] D_ADES     = 3'd2;
    localparam logic [2:0] D_REFILL_L = 3'd3;
    localparam logic [2:0] D_REFILL_S = 3'd4;
    localparam logic [2:0] D_INV_L    = 3'd5;
    localparam logic [2:0] D_INV_S    = 3'd6;
    localparam logic [2:0] D_MOD      = 3'd7;

    localparam logic [4:0] C_INT  = 5'd0;
    localparam logic [4:0] C_MOD  = 5'd1;
    localparam logic [4:0] C_TLBL = 5'd2;
    localparam logic [4:0] C_TLBS = 5'd3;
    localparam logic [4:0] C_ADEL = 5'd4;
    localparam logic [4:0] C_ADES = 5'd5;
    localparam logic [4:0] C_SYS  = 5'd8;
    localparam logic [4:0] C_BP   = 5'd9;
    localparam logic [4:0] C_RI   = 5'd10;
    localparam logic [4:0] C_OV   = 5'd12;

    localparam logic [31:0] VEC_REFILL_DEF  = 32'hBFC0_0200;
    localparam logic [31:0] VEC_GENERAL_DEF = 32'hBFC0_0380;

    typedef enum logic {IDLE, FLUSH} state_t;
endpackage

// File: rtl/exc_ctrl_if.sv
// exc_ctrl_if: MEM-stage/cp0 inputs and cp0 write, flush and redirect outputs
interface exc_ctrl_if;
    logic                       mem_valid;
    logic [31:0]                mem_pc;
    logic                       mem_bd;
    logic [exc_pkg::EXC_W-1:0]  mem_exc;
    logic [31:0]                mem_daddr;
    logic                       mem_eret;
    logic [7:0]                 interrupt_flag;
    logic                       allow_int;
    logic                       in_exl;
    logic [31:0]                epc;
    logic                       en_exp_i;
    logic                       exp_bd;
    logic [31:0]                exp_epc;
    logic [4:0]                 exp_code;
    logic [31:0]                exp_badvaddr;
    logic                       exp_badvaddr_we;
    logic                       clear_exl;
    logic                       flush;
    logic                       redirect_valid;
    logic [31:0]                redirect_pc;
    logic                       busy;

    modport slave (
        input  mem_valid, mem_pc, mem_bd, mem_exc, mem_daddr, mem_eret,
        input  interrupt_flag, allow_int, in_exl, epc,
        output en_exp_i, exp_bd, exp_epc, exp_code, exp_badvaddr, exp_badvaddr_we,
        output clear_exl, flush, redirect_valid, redirect_pc, busy
    );

    modport master (
        output mem_valid, mem_pc, mem_bd, mem_exc, mem_daddr, mem_eret,
        output interrupt_flag, allow_int, in_exl, epc,
        input  en_exp_i, exp_bd, exp_epc, exp_code, exp_badvaddr, exp_badvaddr_we,
        input  clear_exl, flush, redirect_valid, redirect_pc, busy
    );
endinterface

// File: rtl/exc_prio_enc.sv
// exc_prio_enc: picks the highest-priority cause and its cp0 attributes
module exc_prio_enc
    import exc_pkg::*;
(
    input  logic [EXC_W-1:0] i_mem_exc,
    input  logic             i_int_pend,
    output logic             o_hit,
    output logic [4:0]       o_code,
    output logic             o_is_refill,
    output logic             o_is_ifetch,
    output logic             o_bvaddr_we
);
    logic [2:0] w_d;

    assign w_d = i_mem_exc[B_DATA +: 3];

    // fixed priority chain, interrupt first, data-side faults last
    always_comb begin
        o_hit       = i_int_pend | (|i_mem_exc);
        o_code      = C_INT;
        o_is_refill = 1'b0;
        o_is_ifetch = 1'b0;
        o_bvaddr_we = 1'b0;
        if (i_int_pend) begin
            o_code = C_INT;
        end else if (i_mem_exc[B_IF_ADEL] | i_mem_exc[B_IF_REFILL] | i_mem_exc[B_IF_INV]) begin
            o_code      = i_mem_exc[B_IF_ADEL] ? C_ADEL : C_TLBL;
            o_is_refill = ~i_mem_exc[B_IF_ADEL] & i_mem_exc[B_IF_REFILL];
            o_is_ifetch = 1'b1;
            o_bvaddr_we = 1'b1;
        end else if (i_mem_exc[B_RI]) begin
            o_code = C_RI;
        end else if (i_mem_exc[B_OV]) begin
            o_code = C_OV;
        end else if (i_mem_exc[B_SYS]) begin
            o_code = C_SYS;
        end else if (i_mem_exc[B_BP]) begin
            o_code = C_BP;
        end else if (w_d != D_NONE) begin
            o_code      = w_d == D_ADEL ? C_ADEL :
                          w_d == D_ADES ? C_ADES :
                          (w_d == D_REFILL_L || w_d == D_INV_L) ? C_TLBL :
                          (w_d == D_REFILL_S || w_d == D_INV_S) ? C_TLBS : C_MOD;
            o_is_refill = (w_d == D_REFILL_L) || (w_d == D_REFILL_S);
            o_bvaddr_we = 1'b1;
        end
    end
endmodule

// File: rtl/exc_ctrl.sv
// exc_ctrl: exception/ERET commit to cp0, pipeline flush and PC redirect
module exc_ctrl
    import exc_pkg::*;
#(
    parameter int          FLUSH_CYCLES = 2,
    parameter logic [31:0] VEC_REFILL   = VEC_REFILL_DEF,
    parameter logic [31:0] VEC_GENERAL  = VEC_GENERAL_DEF
) (
    input logic       clk,
    input logic       rst,
    exc_ctrl_if.slave bus
);
    localparam int            CW       = $clog2(FLUSH_CYCLES + 1);
    localparam logic [CW-1:0] CNT_INIT = CW'(FLUSH_CYCLES);

    state_t        r_state, w_state_nxt;
    logic [CW-1:0] r_cnt, w_cnt_nxt;
    logic          r_int_pend;
    logic          w_hit, w_is_refill, w_is_ifetch, w_bva_we;
    logic [4:0]    w_code;
    logic          w_det, w_exc;
    logic [31:0]   w_epc, w_vec;
    logic          r_en_exp, r_clear_exl, r_exp_bd, r_bva_we, r_redirect_valid;
    logic [4:0]    r_exp_code;
    logic [31:0]   r_exp_epc, r_bva, r_redirect_pc;

    exc_prio_enc u_enc (
        .i_mem_exc   (bus.mem_exc),
        .i_int_pend  (r_int_pend),
        .o_hit       (w_hit),
        .o_code      (w_code),
        .o_is_refill (w_is_refill),
        .o_is_ifetch (w_is_ifetch),
        .o_bvaddr_we (w_bva_we)
    );

    assign w_det = ~rst & (r_state == IDLE) & bus.mem_valid &
                   ((|bus.mem_exc) | r_int_pend | bus.mem_eret);
    assign w_exc = w_det & w_hit;
    assign w_epc = bus.mem_bd ? bus.mem_pc - 32'd4 : bus.mem_pc;
    assign w_vec = (w_is_refill & ~bus.in_exl) ? VEC_REFILL : VEC_GENERAL;

    assign bus.flush           = ~rst & (w_det | (r_state == FLUSH));
    assign bus.busy            = ~rst & (r_state == FLUSH);
    assign bus.en_exp_i        = r_en_exp;
    assign bus.clear_exl       = r_clear_exl;
    assign bus.exp_bd          = r_exp_bd;
    assign bus.exp_code        = r_exp_code;
    assign bus.exp_epc         = r_exp_epc;
    assign bus.exp_badvaddr    = r_bva;
    assign bus.exp_badvaddr_we = r_bva_we;
    assign bus.redirect_valid  = r_redirect_valid;
    assign bus.redirect_pc     = r_redirect_pc;

    // state, flush countdown and interrupt-pending registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_int_pend <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_int_pend <= bus.allow_int & (|bus.interrupt_flag);
        end
    end

    // IDLE waits for a detect; FLUSH counts down and ignores the pipeline
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        if (r_state == IDLE) begin
            w_state_nxt = w_det ? FLUSH : IDLE;
            w_cnt_nxt   = w_det ? CNT_INIT : r_cnt;
        end else begin
            w_cnt_nxt   = r_cnt - CW'(1);
            w_state_nxt = (r_cnt == CW'(1)) ? IDLE : FLUSH;
        end
    end

    // one-cycle commit pulses and payload, zero whenever nothing is committed
    always_ff @(posedge clk) begin
        if (rst) begin
            r_en_exp         <= 1'b0;
            r_clear_exl      <= 1'b0;
            r_exp_bd         <= 1'b0;
            r_exp_code       <= '0;
            r_exp_epc        <= '0;
            r_bva            <= '0;
            r_bva_we         <= 1'b0;
            r_redirect_valid <= 1'b0;
            r_redirect_pc    <= '0;
        end else begin
            r_en_exp         <= w_exc;
            r_clear_exl      <= w_det & ~w_hit;
            r_exp_bd         <= w_exc & bus.mem_bd & ~bus.in_exl;
            r_exp_code       <= w_exc ? w_code : '0;
            r_exp_epc        <= w_exc ? (bus.in_exl ? bus.epc : w_epc) : '0;
            r_bva            <= (w_exc & w_bva_we) ? (w_is_ifetch ? bus.mem_pc : bus.mem_daddr) : '0;
            r_bva_we         <= w_exc & w_bva_we;
            r_redirect_valid <= w_det;
            r_redirect_pc    <= w_exc ? w_vec : (w_det ? bus.epc : '0);
        end
    end
endmodule

// File: tb/tb_exc_ctrl.sv
// tb_exc_ctrl: directed scenarios plus randomized run against a behavioural model
module tb_exc_ctrl;
    import exc_pkg::*;

    localparam int          FC = 2;
    localparam logic [31:0] VR = 32'hBFC0_0200;
    localparam logic [31:0] VG = 32'hBFC0_0380;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_fail = 0;
    logic [107:0] obs;
    logic [107:0] e;

    exc_ctrl_if bus();

    exc_ctrl #(.FLUSH_CYCLES(FC)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    assign obs = {bus.en_exp_i, bus.clear_exl, bus.exp_bd, bus.exp_code, bus.exp_epc,
                  bus.exp_badvaddr, bus.exp_badvaddr_we, bus.redirect_valid,
                  bus.redirect_pc, bus.flush, bus.busy};

    function automatic logic [107:0] pack(input logic en, clr, bd, input logic [4:0] code,
                                          input logic [31:0] epc_v, bva, input logic we, rv,
                                          input logic [31:0] rpc, input logic fl, bs);
        return {en, clr, bd, code, epc_v, bva, we, rv, rpc, fl, bs};
    endfunction

    // Expected registered result of a detect, from the cause table and EPC/vector rules.
    function automatic logic [107:0] ref_commit(input logic [31:0] pc, input logic bd,
                                                input logic [9:0] exc, input logic [31:0] da,
                                                input logic ip, input logic exl,
                                                input logic [31:0] cp_epc);
        int  if_codes[7];
        int  d_codes[8];
        int  code = 0;
        bit  hit = 0, refill = 0, ifetch = 0, we = 0;
        logic [2:0] d;
        if_codes = '{4, 2, 2, 10, 12, 8, 9};
        d_codes  = '{0, 4, 5, 2, 3, 2, 3, 1};
        d = exc[9:7];
        if (ip) hit = 1;
        for (int i = 0; i < 7; i++)
            if (!hit && exc[i]) begin
                hit = 1; code = if_codes[i]; ifetch = (i < 3); refill = (i == 1); we = (i < 3);
            end
        if (!hit && d != 0) begin
            hit = 1; code = d_codes[d]; we = 1; refill = (d == 3 || d == 4);
        end
        if (!hit) return pack(0, 1, 0, 0, 0, 0, 0, 1, cp_epc, 0, 0);
        return pack(1, 0, bd & !exl, 5'(code), exl ? cp_epc : (bd ? pc - 32'd4 : pc),
                    we ? (ifetch ? pc : da) : 32'd0, we, 1, (refill && !exl) ? VR : VG, 0, 0);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        bus.mem_valid = 0; bus.mem_pc = 0; bus.mem_bd = 0; bus.mem_exc = 0;
        bus.mem_daddr = 0; bus.mem_eret = 0;
    endtask

    task automatic set_op(input logic [31:0] pc, input logic bd, input logic [9:0] exc,
                          input logic [31:0] da, input logic eret);
        bus.mem_valid = 1; bus.mem_pc = pc; bus.mem_bd = bd; bus.mem_exc = exc;
        bus.mem_daddr = da; bus.mem_eret = eret;
    endtask

    task automatic settle(input int n);
        idle_in();
        repeat (n) tick();
    endtask

    task automatic test_reset();
        rst = 1;
        set_op(32'h8000_0000, 0, 10'h008, 0, 0);
        tick(); tick();
        #1;
        if (obs !== '0) begin n_fail++; $display("FAIL reset_hold got %h want 0", obs); end
        n_cmp++;
        idle_in();
        rst = 0;
        tick();
        if (obs !== '0) begin n_fail++; $display("FAIL reset_release got %h want 0", obs); end
        n_cmp++;
    endtask

    task automatic test_ri();
        bus.in_exl = 0;
        tick();
        set_op(32'h8000_1000, 0, 10'(1 << B_RI), 0, 0);
        #1;
        e = pack(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        if (obs !== e) begin n_fail++; $display("FAIL ri_detect got %h want %h", obs, e); end
        n_cmp++;
        tick(); idle_in(); #1;
        e = pack(1, 0, 0, 5'd10, 32'h8000_1000, 0, 0, 1, VG, 1, 1);
        if (obs !== e) begin n_fail++; $display("FAIL ri_commit got %h want %h", obs, e); end
        n_cmp++;
        tick();
        e = pack(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        if (obs !== e) begin n_fail++; $display("FAIL ri_flush2 got %h want %h", obs, e); end
        n_cmp++;
        tick();
        if (obs !== '0) begin n_fail++; $display("FAIL ri_done got %h want 0", obs); end
        n_cmp++;
    endtask

    task automatic test_dtlb();
        bus.in_exl = 0;
        tick();
        set_op(32'h0040_0008, 1, {D_REFILL_S, 7'b0}, 32'h1234_5678, 0);
        tick(); idle_in(); #1;
        e = pack(1, 0, 1, 5'd3, 32'h0040_0004, 32'h1234_5678, 1, 1, VR, 1, 1);
        if (obs !== e) begin n_fail++; $display("FAIL dtlb_refill got %h want %h", obs, e); end
        n_cmp++;
        settle(3);
        bus.in_exl = 1; bus.epc = 32'h8000_0ABC;
        set_op(32'h0040_0008, 1, {D_REFILL_S, 7'b0}, 32'h1234_5678, 0);
        tick(); idle_in(); #1;
        e = pack(1, 0, 0, 5'd3, 32'h8000_0ABC, 32'h1234_5678, 1, 1, VG, 1, 1);
        if (obs !== e) begin n_fail++; $display("FAIL dtlb_exl got %h want %h", obs, e); end
        n_cmp++;
        settle(3);
        bus.in_exl = 0;
    endtask

    task automatic test_interrupt();
        bus.interrupt_flag = 8'h04; bus.allow_int = 1;
        tick();
        bus.interrupt_flag = 0; bus.allow_int = 0;
        set_op(32'h8000_2000, 0, 0, 0, 0);
        tick(); idle_in(); #1;
        e = pack(1, 0, 0, 5'd0, 32'h8000_2000, 0, 0, 1, VG, 1, 1);
        if (obs !== e) begin n_fail++; $display("FAIL int_only got %h want %h", obs, e); end
        n_cmp++;
        settle(3);
        bus.interrupt_flag = 8'h80; bus.allow_int = 1;
        tick();
        bus.interrupt_flag = 0; bus.allow_int = 0;
        set_op(32'h8000_2100, 0, 10'(1 << B_OV), 0, 0);
        tick(); idle_in(); #1;
        e = pack(1, 0, 0, 5'd0, 32'h8000_2100, 0, 0, 1, VG, 1, 1);
        if (obs !== e) begin n_fail++; $display("FAIL int_ov got %h want %h", obs, e); end
        n_cmp++;
        settle(3);
    endtask

    task automatic test_eret();
        bus.epc = 32'h8000_3000;
        set_op(32'h8000_0100, 0, 0, 0, 1);
        #1;
        e = pack(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        if (obs !== e) begin n_fail++; $display("FAIL eret_detect got %h want %h", obs, e); end
        n_cmp++;
        tick(); idle_in(); #1;
        e = pack(0, 1, 0, 0, 0, 0, 0, 1, 32'h8000_3000, 1, 1);
        if (obs !== e) begin n_fail++; $display("FAIL eret_commit got %h want %h", obs, e); end
        n_cmp++;
        settle(3);
        set_op(32'h8000_0200, 0, 10'(1 << B_SYS), 0, 1);
        tick(); idle_in(); #1;
        e = pack(1, 0, 0, 5'd8, 32'h8000_0200, 0, 0, 1, VG, 1, 1);
        if (obs !== e) begin n_fail++; $display("FAIL eret_sys got %h want %h", obs, e); end
        n_cmp++;
        settle(3);
    endtask

    task automatic test_back_to_back();
        set_op(32'h8000_4000, 0, 10'(1 << B_SYS), 0, 0);
        tick();
        set_op(32'h8000_4004, 0, 10'(1 << B_BP), 0, 0);
        #1;
        e = pack(1, 0, 0, 5'd8, 32'h8000_4000, 0, 0, 1, VG, 1, 1);
        if (obs !== e) begin n_fail++; $display("FAIL b2b_sys got %h want %h", obs, e); end
        n_cmp++;
        tick();
        e = pack(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        if (obs !== e) begin n_fail++; $display("FAIL b2b_drop got %h want %h", obs, e); end
        n_cmp++;
        tick();
        e = pack(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        if (obs !== e) begin n_fail++; $display("FAIL b2b_redetect got %h want %h", obs, e); end
        n_cmp++;
        tick(); idle_in(); #1;
        e = pack(1, 0, 0, 5'd9, 32'h8000_4004, 0, 0, 1, VG, 1, 1);
        if (obs !== e) begin n_fail++; $display("FAIL b2b_bp got %h want %h", obs, e); end
        n_cmp++;
        settle(3);
    endtask

    task automatic test_reset_abort();
        set_op(32'h8000_5000, 0, 10'(1 << B_RI), 0, 0);
        tick(); idle_in();
        rst = 1;
        tick();
        if (obs !== '0) begin n_fail++; $display("FAIL abort_rst got %h want 0", obs); end
        n_cmp++;
        rst = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (obs !== '0) begin n_fail++; $display("FAIL abort_after%0d got %h want 0", i, obs); end
            n_cmp++;
        end
    endtask

    task automatic test_random();
        logic [107:0] exp_reg = '0;
        int   t_det = -100;
        logic ip = 0;
        bit   det, bsy;
        int   sel;
        settle(3);
        for (int k = 0; k < 400; k++) begin
            tick();
            sel = $urandom_range(0, 7);
            bus.mem_valid = ($urandom_range(0, 9) < 7);
            bus.mem_exc = sel == 3 ? 10'(1 << $urandom_range(0, 6)) :
                          sel == 4 ? 10'($urandom_range(1, 7) << 7) :
                          sel == 5 ? 10'($urandom) : 10'd0;
            bus.mem_eret = ($urandom_range(0, 3) == 0);
            bus.mem_bd = 1'($urandom);
            bus.mem_pc = $urandom;
            bus.mem_daddr = $urandom;
            bus.in_exl = ($urandom_range(0, 3) == 0);
            bus.epc = $urandom;
            bus.interrupt_flag = ($urandom_range(0, 5) == 0) ? 8'($urandom) : 8'd0;
            bus.allow_int = 1'($urandom);
            #1;
            det = (k > t_det + FC) && bus.mem_valid && (bus.mem_exc != 0 || ip || bus.mem_eret);
            bsy = (k > t_det) && (k <= t_det + FC);
            e = exp_reg | {106'd0, det | bsy, bsy};
            if (obs !== e) begin n_fail++; $display("FAIL rand_c%0d got %h want %h", k, obs, e); end
            n_cmp++;
            exp_reg = det ? ref_commit(bus.mem_pc, bus.mem_bd, bus.mem_exc, bus.mem_daddr, ip,
                                       bus.in_exl, bus.epc) : '0;
            if (det) t_det = k;
            ip = bus.allow_int & (|bus.interrupt_flag);
        end
        settle(4);
    endtask

    initial begin
        idle_in();
        bus.interrupt_flag = 0; bus.allow_int = 0; bus.in_exl = 0; bus.epc = 0;
        test_reset();
        test_ri();
        test_dtlb();
        test_interrupt();
        test_eret();
        test_back_to_back();
        test_reset_abort();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/exc_ctrl.md
# exc_ctrl

Exception/interrupt arbitration stage that sits directly upstream of `cp0`. It samples the MEM-stage instruction's exception flags and `cp0` interrupt state, selects the highest-priority cause, and drives the `cp0` exception write port (`en_exp_i`, `exp_*`, `clear_exl`). It also issues the pipeline flush and the PC redirect to the exception vector or to EPC on ERET, then holds the pipeline flushed for a fixed number of cycles.

## Interface
- FLUSH_CYCLES, 2: cycles `flush` stays high after the detect cycle (≥1)
- VEC_REFILL, 32'hBFC00200: TLB-refill vector (BEV=1)
- VEC_GENERAL, 32'hBFC00380: general exception vector
- clk  in  1  clock; single clock domain
- rst  in  1  synchronous, active-high reset
- mem_valid  in  1  MEM-stage instruction valid
- mem_pc  in  32  MEM-stage PC
- mem_bd  in  1  MEM instruction is in a branch delay slot
- mem_exc  in  10  exception flag vector; bit order defined in `exc_pkg`
- mem_daddr  in  32  data virtual address (BadVAddr for data faults)
- mem_eret  in  1  MEM instruction is ERET
- interrupt_flag  in  8  from cp0
- allow_int  in  1  from cp0
- in_exl  in  1  from cp0
- epc  in  32  from cp0
- en_exp_i  out  1  one-cycle exception commit pulse to cp0
- exp_bd, exp_epc[31:0], exp_code[4:0], exp_badvaddr[31:0], exp_badvaddr_we  out  cp0 exception payload, valid with `en_exp_i`
- clear_exl  out  1  one-cycle ERET pulse to cp0
- flush  out  1  kill IF..MEM
- redirect_valid  out  1  one-cycle PC redirect
- redirect_pc  out  32  redirect target
- busy  out  1  high in FLUSH state

## Operation
- Flag bits / ExcCode: IF_ADEL(4), IF_TLB_REFILL(2), IF_TLB_INV(2), RI(10), OV(12), SYS(8), BP(9), D_ADEL/D_ADES(4/5), D_TLB_REFILL/D_TLB_INV (2 load, 3 store), MOD(1). The store qualifier is carried in the vector.
- Priority, highest first: Int(0) > IF_ADEL > IF_TLB_REFILL > IF_TLB_INV > RI > OV > SYS > BP > D_ADEL/ADES > D_TLB_REFILL > D_TLB_INV > MOD.
- Interrupt pending register `int_pend`: set each cycle to `allow_int & |interrupt_flag`. It attaches to the next `mem_valid` instruction, which is then not committed.
- BadVAddr: IF faults use `mem_pc`; data faults use `mem_daddr`. `exp_badvaddr_we=1` only for AdEL/AdES/TLB/MOD codes.
- EPC: `mem_bd ? mem_pc-4 : mem_pc` (mod 2^32). When `in_exl=1`, `exp_epc=epc` so cp0 keeps its EPC. `exp_bd` is likewise held at 0 when `in_exl=1`.
- Vector: `VEC_REFILL` if the winning cause is a TLB refill and `in_exl=0`; otherwise `VEC_GENERAL`.
- ERET (`mem_eret` with no exception flags): pulse `clear_exl`, set `redirect_pc=epc`, flush.
- Exception and ERET in the same cycle: the exception wins and `clear_exl` stays 0.
- FSM states:
  - IDLE: detect when `mem_valid & (|mem_exc | int_pend | mem_eret)`, then go to FLUSH and load `cnt=FLUSH_CYCLES`.
  - FLUSH: ignore all inputs; `cnt` decrements each cycle; return to IDLE when `cnt==1`.

## Timing
- Detect cycle T: `flush=1` combinationally in T.
- T+1: `en_exp_i` or `clear_exl` pulses for 1 cycle; `redirect_valid` and `redirect_pc` are registered with them; `flush` and `busy` stay high T+1..T+FLUSH_CYCLES.
- Back-to-back: a flagged instruction arriving during FLUSH is dropped (it is flushed). The next detect is possible at T+FLUSH_CYCLES+1.
- Reset: all outputs 0, state IDLE, `int_pend=0`, `cnt=0`. `rst` during FLUSH aborts immediately; no pulse is emitted after reset.

## Structure
- `exc_pkg`: flag-bit indices, ExcCode localparams, default vectors, and state enum {IDLE, FLUSH}.
- Sub-module `exc_prio_enc`: combinational priority encoder with inputs `mem_exc` and `int_pend`, outputs `{hit, code, is_refill, is_ifetch, bvaddr_we}`. The FSM and output registers stay in `exc_ctrl`.

## Test plan
- RI at `mem_pc=0x80001000`, `bd=0`, `in_exl=0`: at T+1, `en_exp_i=1`, `exp_code=10`, `exp_epc=0x80001000`, `badvaddr_we=0`, `redirect_pc=0xBFC00380`; `flush` high for 3 cycles.
- D_TLB_REFILL store, `bd=1`, `pc=0x00400008`, `daddr=0x1234_5678`: `code=3`, `epc=0x00400004`, `exp_bd=1`, `badvaddr=0x12345678`, `redirect_pc=0xBFC00200`. Repeat with `in_exl=1`: vector is 0xBFC00380 and `exp_epc=epc` input.
- `interrupt_flag=0x04`, `allow_int=1`, next `mem_valid` with `pc=0x80002000`: `code=0`, `epc=0x80002000`. Interrupt plus OV on the same instruction: `code=0`.
- ERET with `epc=0x80003000`: `clear_exl` pulse at T+1, `redirect_pc=0x80003000`, `en_exp_i=0`. ERET plus SYS together: `code=8`, `clear_exl=0`.
- SYS then BP on the next cycle: only SYS is committed. BP presented at T+FLUSH_CYCLES+1 is committed.
- `rst` asserted at T+1 of a flush: next cycle all outputs 0, `busy=0`, no further pulses.
